// File: rtl/wbf_arb_pkg.sv
// Shared types and constants for the weight-buffer read arbiter.
// States and mode encodings are used by the arbiter top.
package wbf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WORK  = 2'b01,
        DRAIN = 2'b10
    } arb_state_t;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_FIX = 1'b1;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for reads in flight to the weight buffer.
// Push is ignored when full, pop when empty; clr empties it synchronously.
module arb_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push && !clr)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wbf_rd_arbiter.sv
// Shares the weight-buffer read port between NUM_REQ weight caches and
// steers returned data back to each issuer in order.
module wbf_rd_arbiter
    import wbf_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_OUTSTD = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 TOPARB_CfgVld,
    input  logic                                 TOPARB_CfgMode,
    output logic                                 ARBTOP_CfgRdy,
    output logic                                 ARBTOP_Err,
    input  logic [NUM_REQ-1:0]                   WCAARB_AdrVld,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   WCAARB_Adr,
    output logic [NUM_REQ-1:0]                   ARBWCA_AdrRdy,
    output logic [NUM_REQ-1:0]                   ARBWCA_DatVld,
    output logic [DATA_WIDTH-1:0]                ARBWCA_Dat,
    input  logic [NUM_REQ-1:0]                   WCAARB_DatRdy,
    output logic                                 ARBWBF_AdrVld,
    output logic [ADDR_WIDTH-1:0]                ARBWBF_Adr,
    input  logic                                 WBFARB_AdrRdy,
    input  logic                                 WBFARB_DatVld,
    input  logic [DATA_WIDTH-1:0]                WBFARB_Dat,
    output logic                                 ARBWBF_DatRdy
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTD+1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              mode;
    logic [ID_W-1:0]   rr_ptr;
    logic              err;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   head;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              adr_hs;
    logic              pop;
    logic              clr_fifo;

    // Entering IDLE is the only way out of DRAIN, so it doubles as the clear.
    assign clr_fifo = (state == DRAIN) && (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (TOPARB_CfgVld) state_nxt = WORK;
            WORK:    if (TOPARB_CfgVld) state_nxt = DRAIN;
            DRAIN:   if (count == '0)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Scan from the highest offset down so the lowest offset from the start point wins.
    always_comb begin
        grant = '0;
        cand  = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (mode == MODE_FIX)
                cand = ID_W'(i);
            else
                cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (WCAARB_AdrVld[cand])
                grant = cand;
        end
    end

    assign ARBWBF_AdrVld = (state == WORK) && !full && (|WCAARB_AdrVld);
    assign ARBWBF_Adr    = ARBWBF_AdrVld ? WCAARB_Adr[grant] : '0;
    assign adr_hs        = ARBWBF_AdrVld & WBFARB_AdrRdy;
    assign ARBWBF_DatRdy = !empty && WCAARB_DatRdy[head];
    assign pop           = WBFARB_DatVld & ARBWBF_DatRdy;
    assign ARBWCA_Dat    = (WBFARB_DatVld && !empty) ? WBFARB_Dat : '0;
    assign ARBTOP_CfgRdy = (state == IDLE);
    assign ARBTOP_Err    = err;

    always_comb begin
        ARBWCA_AdrRdy = '0;
        ARBWCA_DatVld = '0;
        if (adr_hs)
            ARBWCA_AdrRdy[grant] = 1'b1;
        if (WBFARB_DatVld && !empty)
            ARBWCA_DatVld[head] = 1'b1;
    end

    // Priority only rotates on an accepted address, never on a stalled buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= MODE_RR;
            rr_ptr <= '0;
            err    <= 1'b0;
        end else begin
            if (state == IDLE && TOPARB_CfgVld)
                mode <= TOPARB_CfgMode;
            if (clr_fifo)
                rr_ptr <= '0;
            else if (adr_hs && mode == MODE_RR)
                rr_ptr <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
            if (clr_fifo)
                err <= 1'b0;
            else if (WBFARB_DatVld && empty)
                err <= 1'b1;
        end
    end

    arb_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTD)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_fifo),
        .push      (adr_hs),
        .push_data (grant),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_wbf_rd_arbiter.sv
// Directed self-checking bench for wbf_rd_arbiter: arbitration modes,
// full FIFO, return backpressure, drain, error flag and reset.
module tb_wbf_rd_arbiter;

    logic            clk;
    logic            rst_n;
    logic            TOPARB_CfgVld;
    logic            TOPARB_CfgMode;
    logic            ARBTOP_CfgRdy;
    logic            ARBTOP_Err;
    logic [3:0]      WCAARB_AdrVld;
    logic [3:0][7:0] WCAARB_Adr;
    logic [3:0]      ARBWCA_AdrRdy;
    logic [3:0]      ARBWCA_DatVld;
    logic [7:0]      ARBWCA_Dat;
    logic [3:0]      WCAARB_DatRdy;
    logic            ARBWBF_AdrVld;
    logic [7:0]      ARBWBF_Adr;
    logic            WBFARB_AdrRdy;
    logic            WBFARB_DatVld;
    logic [7:0]      WBFARB_Dat;
    logic            ARBWBF_DatRdy;

    int total;
    int bad;

    wbf_rd_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_OUTSTD(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .TOPARB_CfgVld  (TOPARB_CfgVld),
        .TOPARB_CfgMode (TOPARB_CfgMode),
        .ARBTOP_CfgRdy  (ARBTOP_CfgRdy),
        .ARBTOP_Err     (ARBTOP_Err),
        .WCAARB_AdrVld  (WCAARB_AdrVld),
        .WCAARB_Adr     (WCAARB_Adr),
        .ARBWCA_AdrRdy  (ARBWCA_AdrRdy),
        .ARBWCA_DatVld  (ARBWCA_DatVld),
        .ARBWCA_Dat     (ARBWCA_Dat),
        .WCAARB_DatRdy  (WCAARB_DatRdy),
        .ARBWBF_AdrVld  (ARBWBF_AdrVld),
        .ARBWBF_Adr     (ARBWBF_Adr),
        .WBFARB_AdrRdy  (WBFARB_AdrRdy),
        .WBFARB_DatVld  (WBFARB_DatVld),
        .WBFARB_Dat     (WBFARB_Dat),
        .ARBWBF_DatRdy  (ARBWBF_DatRdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; the DUT samples on the rising edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_cfg(input logic m);
        TOPARB_CfgVld  = 1'b1;
        TOPARB_CfgMode = m;
        tick();
        TOPARB_CfgVld  = 1'b0;
    endtask

    task automatic stop_cfg();
        TOPARB_CfgVld = 1'b1;
        tick();
        TOPARB_CfgVld = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        #1;
        total++;
        if (ARBTOP_CfgRdy !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_cfgrdy got=%b exp=1", ARBTOP_CfgRdy);
        end
        total++;
        if ({ARBTOP_Err, ARBWBF_AdrVld, ARBWBF_DatRdy, ARBWCA_AdrRdy, ARBWCA_DatVld} !== 11'b0) begin
            bad++; $display("[TB] FAIL reset_ctrl got=%b exp=0",
                {ARBTOP_Err, ARBWBF_AdrVld, ARBWBF_DatRdy, ARBWCA_AdrRdy, ARBWCA_DatVld});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        logic [1:0] pg;
        start_cfg(1'b0);
        for (int k = 0; k < 6; k++) begin
            g  = 2'(k % 4);
            pg = 2'((k + 3) % 4);
            WCAARB_AdrVld = (k < 5) ? 4'hF : 4'h0;
            WBFARB_DatVld = (k >= 1);
            WBFARB_Dat    = ~(8'h10 + 8'(pg));
            #1;
            if (k < 5) begin
                total++;
                if (ARBWCA_AdrRdy !== (4'b1 << g) || ARBWBF_Adr !== 8'h10 + 8'(g)) begin
                    bad++; $display("[TB] FAIL rr_grant k=%0d got=%b/%h exp=%b/%h",
                        k, ARBWCA_AdrRdy, ARBWBF_Adr, 4'b1 << g, 8'h10 + 8'(g));
                end
            end else begin
                total++;
                if (ARBWBF_AdrVld !== 1'b0) begin
                    bad++; $display("[TB] FAIL rr_idle_adrvld got=%b exp=0", ARBWBF_AdrVld);
                end
            end
            if (k >= 1) begin
                total++;
                if (ARBWCA_DatVld !== (4'b1 << pg) || ARBWCA_Dat !== ~(8'h10 + 8'(pg))) begin
                    bad++; $display("[TB] FAIL rr_return k=%0d got=%b/%h exp=%b/%h",
                        k, ARBWCA_DatVld, ARBWCA_Dat, 4'b1 << pg, ~(8'h10 + 8'(pg)));
                end
            end
            tick();
        end
        WBFARB_DatVld = 1'b0;
        stop_cfg();
    endtask

    task automatic test_fixed_priority();
        start_cfg(1'b1);
        for (int k = 0; k < 5; k++) begin
            WCAARB_AdrVld = (k < 3) ? 4'b1010 : (k == 3) ? 4'b1000 : 4'b0000;
            WBFARB_DatVld = (k >= 1);
            WBFARB_Dat    = (k == 4) ? ~8'h13 : ~8'h11;
            #1;
            if (k < 4) begin
                total++;
                if (ARBWCA_AdrRdy !== ((k < 3) ? 4'b0010 : 4'b1000)) begin
                    bad++; $display("[TB] FAIL fix_grant k=%0d got=%b exp=%b",
                        k, ARBWCA_AdrRdy, (k < 3) ? 4'b0010 : 4'b1000);
                end
            end
            if (k >= 1) begin
                total++;
                if (ARBWCA_DatVld !== ((k == 4) ? 4'b1000 : 4'b0010)) begin
                    bad++; $display("[TB] FAIL fix_return k=%0d got=%b exp=%b",
                        k, ARBWCA_DatVld, (k == 4) ? 4'b1000 : 4'b0010);
                end
            end
            tick();
        end
        WBFARB_DatVld = 1'b0;
        stop_cfg();
    endtask

    task automatic test_full();
        start_cfg(1'b0);
        WCAARB_AdrVld = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (ARBWCA_AdrRdy !== (4'b1 << k)) begin
                bad++; $display("[TB] FAIL full_fill k=%0d got=%b exp=%b", k, ARBWCA_AdrRdy, 4'b1 << k);
            end
            tick();
        end
        #1;
        total++;
        if (ARBWBF_AdrVld !== 1'b0) begin
            bad++; $display("[TB] FAIL full_block got=%b exp=0", ARBWBF_AdrVld);
        end
        tick();
        WBFARB_DatVld = 1'b1;
        WBFARB_Dat    = ~8'h10;
        #1;
        total++;
        if (ARBWBF_AdrVld !== 1'b0 || ARBWCA_DatVld !== 4'b0001 || ARBWBF_DatRdy !== 1'b1) begin
            bad++; $display("[TB] FAIL full_pop got=%b/%b/%b exp=0/0001/1",
                ARBWBF_AdrVld, ARBWCA_DatVld, ARBWBF_DatRdy);
        end
        tick();
        WBFARB_DatVld = 1'b0;
        #1;
        total++;
        if (ARBWBF_AdrVld !== 1'b1 || ARBWCA_AdrRdy !== 4'b0001) begin
            bad++; $display("[TB] FAIL full_regrant got=%b/%b exp=1/0001", ARBWBF_AdrVld, ARBWCA_AdrRdy);
        end
        tick();
        WCAARB_AdrVld = 4'h0;
        for (int r = 0; r < 4; r++) begin
            WBFARB_DatVld = 1'b1;
            WBFARB_Dat    = 8'h60 + 8'(r);
            #1;
            total++;
            if (ARBWCA_DatVld !== (4'b1 << ((r + 1) % 4))) begin
                bad++; $display("[TB] FAIL full_drain r=%0d got=%b exp=%b",
                    r, ARBWCA_DatVld, 4'b1 << ((r + 1) % 4));
            end
            tick();
        end
        WBFARB_DatVld = 1'b0;
        stop_cfg();
    endtask

    task automatic test_backpressure();
        start_cfg(1'b1);
        WCAARB_AdrVld = 4'b0100;
        #1;
        total++;
        if (ARBWCA_AdrRdy !== 4'b0100) begin
            bad++; $display("[TB] FAIL bp_grant got=%b exp=0100", ARBWCA_AdrRdy);
        end
        tick();
        WCAARB_AdrVld = 4'b0000;
        WCAARB_DatRdy = 4'b1011;
        WBFARB_DatVld = 1'b1;
        WBFARB_Dat    = 8'hA5;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++;
            if (ARBWBF_DatRdy !== 1'b0 || ARBWCA_DatVld !== 4'b0100) begin
                bad++; $display("[TB] FAIL bp_stall k=%0d got=%b/%b exp=0/0100", k, ARBWBF_DatRdy, ARBWCA_DatVld);
            end
            tick();
        end
        WCAARB_DatRdy = 4'hF;
        #1;
        total++;
        if (ARBWBF_DatRdy !== 1'b1 || ARBWCA_DatVld !== 4'b0100 || ARBWCA_Dat !== 8'hA5) begin
            bad++; $display("[TB] FAIL bp_release got=%b/%b/%h exp=1/0100/a5",
                ARBWBF_DatRdy, ARBWCA_DatVld, ARBWCA_Dat);
        end
        tick();
        #1;
        total++;
        if (ARBWCA_DatVld !== 4'b0000 || ARBWBF_DatRdy !== 1'b0) begin
            bad++; $display("[TB] FAIL bp_empty got=%b/%b exp=0000/0", ARBWCA_DatVld, ARBWBF_DatRdy);
        end
        WBFARB_DatVld = 1'b0;
        stop_cfg();
    endtask

    task automatic test_drain();
        start_cfg(1'b0);
        WCAARB_AdrVld = 4'hF;
        tick();
        tick();
        tick();
        WCAARB_AdrVld = 4'h0;
        TOPARB_CfgVld = 1'b1;
        tick();
        TOPARB_CfgVld = 1'b0;
        WCAARB_AdrVld = 4'hF;
        for (int r = 0; r < 3; r++) begin
            WBFARB_DatVld = 1'b1;
            WBFARB_Dat    = 8'h50 + 8'(r);
            #1;
            total++;
            if (ARBWBF_AdrVld !== 1'b0 || ARBTOP_CfgRdy !== 1'b0 ||
                ARBWCA_DatVld !== (4'b1 << r) || ARBWCA_Dat !== 8'h50 + 8'(r)) begin
                bad++; $display("[TB] FAIL drain_ret r=%0d got=%b/%b/%b/%h exp=0/0/%b/%h",
                    r, ARBWBF_AdrVld, ARBTOP_CfgRdy, ARBWCA_DatVld, ARBWCA_Dat, 4'b1 << r, 8'h50 + 8'(r));
            end
            tick();
        end
        WBFARB_DatVld = 1'b0;
        #1;
        total++;
        if (ARBTOP_CfgRdy !== 1'b0) begin
            bad++; $display("[TB] FAIL drain_cnt0 got=%b exp=0", ARBTOP_CfgRdy);
        end
        tick();
        #1;
        total++;
        if (ARBTOP_CfgRdy !== 1'b1 || ARBWBF_AdrVld !== 1'b0) begin
            bad++; $display("[TB] FAIL drain_idle got=%b/%b exp=1/0", ARBTOP_CfgRdy, ARBWBF_AdrVld);
        end
        WCAARB_AdrVld = 4'h0;
        tick();
    endtask

    task automatic test_error_reset();
        WBFARB_DatVld = 1'b1;
        WBFARB_Dat    = 8'h77;
        #1;
        total++;
        if (ARBWBF_DatRdy !== 1'b0 || ARBWCA_DatVld !== 4'b0000) begin
            bad++; $display("[TB] FAIL err_nodata got=%b/%b exp=0/0000", ARBWBF_DatRdy, ARBWCA_DatVld);
        end
        tick();
        WBFARB_DatVld = 1'b0;
        tick();
        #1;
        total++;
        if (ARBTOP_Err !== 1'b1) begin
            bad++; $display("[TB] FAIL err_sticky got=%b exp=1", ARBTOP_Err);
        end
        start_cfg(1'b0);
        WCAARB_AdrVld = 4'hF;
        tick();
        tick();
        WBFARB_DatVld = 1'b1;
        WBFARB_Dat    = 8'h33;
        rst_n = 1'b0;
        #1;
        total++;
        if (ARBTOP_CfgRdy !== 1'b1 || ARBTOP_Err !== 1'b0 || ARBWBF_AdrVld !== 1'b0 ||
            ARBWBF_Adr !== 8'h00 || ARBWCA_DatVld !== 4'b0000 || ARBWCA_Dat !== 8'h00 ||
            ARBWBF_DatRdy !== 1'b0 || ARBWCA_AdrRdy !== 4'b0000) begin
            bad++; $display("[TB] FAIL rst_mid got=%b%b%b%h%b%h%b%b exp=1,0,0,00,0000,00,0,0000",
                ARBTOP_CfgRdy, ARBTOP_Err, ARBWBF_AdrVld, ARBWBF_Adr, ARBWCA_DatVld,
                ARBWCA_Dat, ARBWBF_DatRdy, ARBWCA_AdrRdy);
        end
        tick();
        WCAARB_AdrVld = 4'h0;
        rst_n = 1'b1;
        tick();
        #1;
        total++;
        if (ARBWCA_DatVld !== 4'b0000 || ARBWBF_DatRdy !== 1'b0) begin
            bad++; $display("[TB] FAIL rst_nodeliver got=%b/%b exp=0000/0", ARBWCA_DatVld, ARBWBF_DatRdy);
        end
        WBFARB_DatVld = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n          = 1'b0;
        TOPARB_CfgVld  = 1'b0;
        TOPARB_CfgMode = 1'b0;
        WCAARB_AdrVld  = 4'h0;
        for (int i = 0; i < 4; i++)
            WCAARB_Adr[i] = 8'h10 + 8'(i);
        WCAARB_DatRdy  = 4'hF;
        WBFARB_AdrRdy  = 1'b1;
        WBFARB_DatVld  = 1'b0;
        WBFARB_Dat     = 8'h00;
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_full();
        test_backpressure();
        test_drain();
        test_error_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
